bp_me_axil_reg_slave: RTL and testbench
=======================================

BP_ME_AXIL_REG_SLAVE -- requirements
Module: bp_me_axil_reg_slave

Purpose: AXI4-Lite subordinate register bank; the downstream endpoint for an AXI-lite master stage in the I/O path.

Interface
REQ-001 Parameter axil_data_width_p, default 32, data width in bits; only 32 or 64 are legal.
REQ-002 Parameter axil_addr_width_p, default 32, address width in bits.
REQ-003 Parameter num_regs_p, default 8, number of data-width registers; must be at least 2.
REQ-004 Parameter base_addr_p, default 0, byte address of register 0; aligned to num_regs_p*(axil_data_width_p>>3).
REQ-005 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-006 reset_i  input  1  synchronous, active-high reset.
REQ-007 s_axil_awaddr_i / awprot_i / awvalid_i  input  axil_addr_width_p / 3 / 1  write address channel; awprot ignored.
REQ-008 s_axil_awready_o  output  1  write address ready.
REQ-009 s_axil_wdata_i / wstrb_i / wvalid_i  input  axil_data_width_p / axil_data_width_p>>3 / 1  write data channel.
REQ-010 s_axil_wready_o  output  1  write data ready.
REQ-011 s_axil_bresp_o / bvalid_o  output  2 / 1; s_axil_bready_i  input  1  write response channel.
REQ-012 s_axil_araddr_i / arprot_i / arvalid_i  input  axil_addr_width_p / 3 / 1; s_axil_arready_o  output  1  read address channel; arprot ignored.
REQ-013 s_axil_rdata_o / rresp_o / rvalid_o  output  axil_data_width_p / 2 / 1; s_axil_rready_i  input  1  read data channel.
REQ-014 regs_o  output  num_regs_p*axil_data_width_p  flattened register contents, register i at bits [i*W +: W].
REQ-015 reg_w_v_o  output  num_regs_p  one-cycle pulse per register, high on the cycle its committed write becomes visible on regs_o.

Function
REQ-016 Address decode: off = addr - base_addr_p; a request is legal iff off < num_regs_p*(W/8) and off[log2(W/8)-1:0] == 0; index = off >> log2(W/8).
REQ-017 Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
REQ-018 W_IDLE: awready=1 and wready=1.
REQ-019 W_IDLE transitions: AW handshake alone -> W_HAVE_AW, capturing the address; W handshake alone -> W_HAVE_W, capturing data and strobe; both in the same cycle -> W_RESP.
REQ-020 W_HAVE_AW: awready=0, wready=1; W handshake -> W_RESP.
REQ-021 W_HAVE_W: awready=1, wready=0; AW handshake -> W_RESP.
REQ-022 Commit on the edge entering W_RESP: a legal write updates byte k of regs[index] iff wstrb[k]=1, and reg_w_v_o[index] pulses for exactly the next cycle; an illegal write changes nothing and produces no pulse.
REQ-023 W_RESP: awready=0, wready=0, bvalid=1; bresp=2'b00 for a legal write, 2'b10 (SLVERR) for an illegal one; bvalid/bresp stay stable until bready; the handshake returns the FSM to W_IDLE.
REQ-024 Write latency: bvalid rises exactly 1 cycle after the later of the AW/W handshakes.
REQ-025 Read FSM states: R_IDLE (arready=1, rvalid=0) and R_RESP (arready=0, rvalid=1).
REQ-026 An AR handshake moves the FSM to R_RESP; rdata and rresp are registered at the handshake edge from the pre-edge register contents.
REQ-027 Read response: legal -> rdata=regs[index], rresp=2'b00; illegal -> rdata=0, rresp=2'b10.
REQ-028 rvalid/rdata/rresp hold stable until the rready handshake, which returns the FSM to R_IDLE; read latency is 1 cycle.
REQ-029 Read and write FSMs are independent and run concurrently.
REQ-030 A read accepted on the same edge as a write commit to the same register returns the old value.
REQ-031 At most one write and one read are outstanding at a time; no request is dropped while a ready is low.

Reset
REQ-032 While reset_i=1: awready, wready, arready, bvalid, rvalid = 0; bresp, rresp, rdata = 0; reg_w_v_o = 0.
REQ-033 On the first cycle after reset deassertion: all registers = 0, both FSMs in idle, and awready/wready/arready = 1.
REQ-034 Reset asserted mid-transaction abandons all captured AW/W/AR state and any pending response without committing.

Verification
REQ-035 Legal write: base=0, AW addr 0x4 and W data 0xDEADBEEF with wstrb 0xF in the same cycle -> next cycle bvalid=1, bresp=0, regs[1]=0xDEADBEEF, reg_w_v_o=0x02.
REQ-036 AW before W: AW 0x8 in cycle 0, W 0x11223344 with wstrb 0x5 in cycle 3, starting from regs[2]=0xFFFFFFFF -> wready high through cycle 3, bvalid at cycle 4, regs[2]=0xFF22FF44.
REQ-037 Backpressure: bready held 0 for 5 cycles -> bvalid and bresp stable, awready=wready=0 throughout, FSM returns to idle the cycle after bready=1.
REQ-038 Illegal access: read 0x20 (num_regs_p=8) -> rresp=2'b10, rdata=0; write 0x6 -> bresp=2'b10, no register changes, reg_w_v_o=0.
REQ-039 Collision: read of 0x4 accepted on the same edge as a write of 0xA5A5A5A5 to 0x4 commits, starting from regs[1]=0x0 -> rdata=0x0; a later read of 0x4 returns 0xA5A5A5A5.
REQ-040 Reset mid-write: AW accepted, then reset for 1 cycle, then W -> no commit and no bvalid; the FSM then waits for a fresh AW.

Source files
------------

// File: rtl/bp_me_axil_reg_slave.sv
// AXI4-Lite subordinate register bank: independent write/read FSMs over a
// small array of data-width registers, with per-register write-commit pulses.
module bp_me_axil_reg_slave #(
    parameter int                           axil_data_width_p = 32,
    parameter int                           axil_addr_width_p = 32,
    parameter int                           num_regs_p        = 8,
    parameter logic [axil_addr_width_p-1:0] base_addr_p       = '0
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,

    input  logic [axil_addr_width_p-1:0]            s_axil_awaddr_i,
    input  logic [2:0]                              s_axil_awprot_i,
    input  logic                                    s_axil_awvalid_i,
    output logic                                    s_axil_awready_o,

    input  logic [axil_data_width_p-1:0]            s_axil_wdata_i,
    input  logic [(axil_data_width_p>>3)-1:0]       s_axil_wstrb_i,
    input  logic                                    s_axil_wvalid_i,
    output logic                                    s_axil_wready_o,

    output logic [1:0]                              s_axil_bresp_o,
    output logic                                    s_axil_bvalid_o,
    input  logic                                    s_axil_bready_i,

    input  logic [axil_addr_width_p-1:0]            s_axil_araddr_i,
    input  logic [2:0]                              s_axil_arprot_i,
    input  logic                                    s_axil_arvalid_i,
    output logic                                    s_axil_arready_o,

    output logic [axil_data_width_p-1:0]            s_axil_rdata_o,
    output logic [1:0]                              s_axil_rresp_o,
    output logic                                    s_axil_rvalid_o,
    input  logic                                    s_axil_rready_i,

    output logic [num_regs_p*axil_data_width_p-1:0] regs_o,
    output logic [num_regs_p-1:0]                   reg_w_v_o
);

    localparam int W  = axil_data_width_p;
    localparam int AW = axil_addr_width_p;
    localparam int NB = W / 8;
    localparam int LG = $clog2(NB);
    localparam int IW = $clog2(num_regs_p);
    localparam logic [AW-1:0] span_c        = AW'(num_regs_p * NB);
    localparam logic [1:0]    resp_okay_c   = 2'b00;
    localparam logic [1:0]    resp_slverr_c = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_RESP} r_state_e;

    w_state_e w_state_reg, w_state_next;
    r_state_e r_state_reg, r_state_next;

    logic [AW-1:0]         awaddr_reg;
    logic [W-1:0]          wdata_reg;
    logic [NB-1:0]         wstrb_reg;
    logic [1:0]            bresp_reg;
    logic [1:0]            rresp_reg;
    logic [W-1:0]          rdata_reg;
    logic [num_regs_p-1:0] reg_w_v_reg;
    logic [num_regs_p-1:0] reg_we;
    logic [W-1:0]          regs_arr [num_regs_p];

    logic          awready, wready, arready;
    logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic          commit;
    logic [AW-1:0] commit_addr, wr_off, rd_off;
    logic [W-1:0]  commit_data;
    logic [NB-1:0] commit_strb;
    logic          wr_legal, rd_legal;
    logic [IW-1:0] wr_idx, rd_idx;
    logic          unused_prot;

    assign unused_prot = ^{s_axil_awprot_i, s_axil_arprot_i};

    // Handshake-facing outputs are forced low while reset is held, not just after its edge.
    assign awready = !reset_i && (w_state_reg == W_IDLE || w_state_reg == W_HAVE_W);
    assign wready  = !reset_i && (w_state_reg == W_IDLE || w_state_reg == W_HAVE_AW);
    assign arready = !reset_i && (r_state_reg == R_IDLE);

    assign s_axil_awready_o = awready;
    assign s_axil_wready_o  = wready;
    assign s_axil_arready_o = arready;
    assign s_axil_bvalid_o  = !reset_i && (w_state_reg == W_RESP);
    assign s_axil_rvalid_o  = !reset_i && (r_state_reg == R_RESP);
    assign s_axil_bresp_o   = reset_i ? 2'b00 : bresp_reg;
    assign s_axil_rresp_o   = reset_i ? 2'b00 : rresp_reg;
    assign s_axil_rdata_o   = reset_i ? '0 : rdata_reg;
    assign reg_w_v_o        = reset_i ? '0 : reg_w_v_reg;

    assign aw_hs = s_axil_awvalid_i && awready;
    assign w_hs  = s_axil_wvalid_i && wready;
    assign b_hs  = s_axil_bvalid_o && s_axil_bready_i;
    assign ar_hs = s_axil_arvalid_i && arready;
    assign r_hs  = s_axil_rvalid_o && s_axil_rready_i;

    always_comb begin
        w_state_next = w_state_reg;
        unique case (w_state_reg)
            W_IDLE: begin
                if (aw_hs && w_hs)  w_state_next = W_RESP;
                else if (aw_hs)     w_state_next = W_HAVE_AW;
                else if (w_hs)      w_state_next = W_HAVE_W;
            end
            W_HAVE_AW: if (w_hs)  w_state_next = W_RESP;
            W_HAVE_W:  if (aw_hs) w_state_next = W_RESP;
            W_RESP:    if (b_hs)  w_state_next = W_IDLE;
            default:              w_state_next = W_IDLE;
        endcase
    end

    // The half that arrives last comes straight from the bus; the other from the capture registers.
    assign commit      = (w_state_reg != W_RESP) && (w_state_next == W_RESP);
    assign commit_addr = (w_state_reg == W_HAVE_AW) ? awaddr_reg : s_axil_awaddr_i;
    assign commit_data = (w_state_reg == W_HAVE_W) ? wdata_reg : s_axil_wdata_i;
    assign commit_strb = (w_state_reg == W_HAVE_W) ? wstrb_reg : s_axil_wstrb_i;

    assign wr_off   = commit_addr - base_addr_p;
    assign wr_legal = (wr_off < span_c) && (wr_off[LG-1:0] == '0);
    assign wr_idx   = IW'(wr_off >> LG);

    assign rd_off   = s_axil_araddr_i - base_addr_p;
    assign rd_legal = (rd_off < span_c) && (rd_off[LG-1:0] == '0);
    assign rd_idx   = IW'(rd_off >> LG);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            w_state_reg <= W_IDLE;
            awaddr_reg  <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            bresp_reg   <= 2'b00;
            reg_w_v_reg <= '0;
        end else begin
            w_state_reg <= w_state_next;
            if (aw_hs) awaddr_reg <= s_axil_awaddr_i;
            if (w_hs) begin
                wdata_reg <= s_axil_wdata_i;
                wstrb_reg <= s_axil_wstrb_i;
            end
            reg_w_v_reg <= reg_we;
            if (commit) bresp_reg <= wr_legal ? resp_okay_c : resp_slverr_c;
        end
    end

    for (genvar gi = 0; gi < num_regs_p; gi++) begin : g_reg
        logic [W-1:0] data_reg;

        assign reg_we[gi] = commit && wr_legal && (wr_idx == IW'(gi));

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                data_reg <= '0;
            end else if (reg_we[gi]) begin
                for (int k = 0; k < NB; k++) begin
                    if (commit_strb[k]) data_reg[8*k +: 8] <= commit_data[8*k +: 8];
                end
            end
        end

        assign regs_arr[gi]      = data_reg;
        assign regs_o[gi*W +: W] = data_reg;
    end

    always_comb begin
        r_state_next = r_state_reg;
        unique case (r_state_reg)
            R_IDLE:  if (ar_hs) r_state_next = R_RESP;
            R_RESP:  if (r_hs)  r_state_next = R_IDLE;
            default:            r_state_next = R_IDLE;
        endcase
    end

    // Read data samples pre-edge contents, so a same-edge write commit is not yet visible.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state_reg <= R_IDLE;
            rdata_reg   <= '0;
            rresp_reg   <= 2'b00;
        end else begin
            r_state_reg <= r_state_next;
            if (ar_hs) begin
                rdata_reg <= rd_legal ? regs_arr[rd_idx] : '0;
                rresp_reg <= rd_legal ? resp_okay_c : resp_slverr_c;
            end
        end
    end

endmodule

// File: tb/tb_bp_me_axil_reg_slave.sv
// Bench for bp_me_axil_reg_slave: directed table, randomized traffic against
// an array model of the register bank, plus reset and collision sequences.
module tb_bp_me_axil_reg_slave;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  awaddr, wdata, araddr, rdata;
    logic [2:0]   awprot, arprot;
    logic [3:0]   wstrb;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [1:0]   bresp, rresp;
    logic [255:0] regs;
    logic [7:0]   reg_w_v;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model [N];

    typedef struct {
        bit          is_rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          d1;
        int          d2;
        int          d3;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;
    vec_t vecs [14];

    always #5 clk = ~clk;

    bp_me_axil_reg_slave dut (
        .clk_i(clk), .reset_i(reset),
        .s_axil_awaddr_i(awaddr), .s_axil_awprot_i(awprot), .s_axil_awvalid_i(awvalid),
        .s_axil_awready_o(awready),
        .s_axil_wdata_i(wdata), .s_axil_wstrb_i(wstrb), .s_axil_wvalid_i(wvalid),
        .s_axil_wready_o(wready),
        .s_axil_bresp_o(bresp), .s_axil_bvalid_o(bvalid), .s_axil_bready_i(bready),
        .s_axil_araddr_i(araddr), .s_axil_arprot_i(arprot), .s_axil_arvalid_i(arvalid),
        .s_axil_arready_o(arready),
        .s_axil_rdata_o(rdata), .s_axil_rresp_o(rresp), .s_axil_rvalid_o(rvalid),
        .s_axil_rready_i(rready),
        .regs_o(regs), .reg_w_v_o(reg_w_v)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit m_legal(input logic [31:0] a);
        return (a < 32'd32) && (a % 4 == 0);
    endfunction

    function automatic logic [255:0] m_flat();
        logic [255:0] f;
        for (int i = 0; i < N; i++) f[i*32 +: 32] = model[i];
        return f;
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly, input logic [1:0] exp_resp);
        bit aw_done = 0;
        bit w_done  = 0;
        bit hs_aw, hs_w;
        int cyc = 0;
        logic [7:0] exp_pulse;
        while (!(aw_done && w_done) && cyc < 40) begin
            awaddr  = addr;
            wdata   = data;
            wstrb   = strb;
            awvalid = !aw_done && cyc >= aw_dly;
            wvalid  = !w_done && cyc >= w_dly;
            if (!aw_done && !w_done) check("wr_idle_ready", {awready, wready}, 2'b11);
            if (aw_done)             check("wr_have_aw_ready", {awready, wready}, 2'b01);
            if (w_done)              check("wr_have_w_ready", {awready, wready}, 2'b10);
            check("wr_no_early_bvalid", bvalid, 1'b0);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(posedge clk); #1;
            aw_done |= hs_aw;
            w_done  |= hs_w;
            cyc++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            n_checks++;
            n_fail++;
            $display("FAIL wr_timeout: got no handshake expected handshake addr=%h", addr);
            return;
        end
        exp_pulse = 8'h00;
        if (m_legal(addr)) begin
            exp_pulse = 8'h01 << addr[4:2];
            for (int k = 0; k < 4; k++)
                if (strb[k]) model[addr[4:2]][8*k +: 8] = data[8*k +: 8];
        end
        check("wr_bvalid", bvalid, 1'b1);
        check("wr_bresp", bresp, exp_resp);
        check("wr_pulse", reg_w_v, exp_pulse);
        check("wr_regs", regs, m_flat());
        check("wr_resp_ready", {awready, wready}, 2'b00);
        for (int i = 0; i < b_dly; i++) begin
            @(posedge clk); #1;
            check("wr_bp_bvalid", bvalid, 1'b1);
            check("wr_bp_bresp", bresp, exp_resp);
            check("wr_bp_ready", {awready, wready}, 2'b00);
            check("wr_bp_pulse", reg_w_v, 8'h00);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("wr_done_bvalid", bvalid, 1'b0);
        check("wr_done_ready", {awready, wready}, 2'b11);
        check("wr_done_pulse", reg_w_v, 8'h00);
        $display("WR addr=%h data=%h strb=%h aw_dly=%0d w_dly=%0d b_dly=%0d bresp=%0d", addr, data, strb,
                 aw_dly, w_dly, b_dly, bresp);
    endtask

    task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
        bit done = 0;
        bit hs;
        int cyc = 0;
        while (!done && cyc < 40) begin
            araddr  = addr;
            arvalid = cyc >= ar_dly;
            check("rd_idle_arready", arready, 1'b1);
            check("rd_no_early_rvalid", rvalid, 1'b0);
            hs = arvalid && arready;
            @(posedge clk); #1;
            done = hs;
            cyc++;
        end
        arvalid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL rd_timeout: got no handshake expected handshake addr=%h", addr);
            return;
        end
        check("rd_rvalid", rvalid, 1'b1);
        check("rd_rdata", rdata, exp_data);
        check("rd_rresp", rresp, exp_resp);
        check("rd_resp_arready", arready, 1'b0);
        for (int i = 0; i < r_dly; i++) begin
            @(posedge clk); #1;
            check("rd_bp_rvalid", rvalid, 1'b1);
            check("rd_bp_rdata", rdata, exp_data);
            check("rd_bp_rresp", rresp, exp_resp);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("rd_done_rvalid", rvalid, 1'b0);
        check("rd_done_arready", arready, 1'b1);
        $display("RD addr=%h rdata=%h rresp=%0d ar_dly=%0d r_dly=%0d", addr, rdata, rresp, ar_dly, r_dly);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d, old;
        int r;

        reset = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        for (int i = 0; i < N; i++) model[i] = '0;

        vecs[0]  = '{0, 32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 32'hDEADBEEF, 2'b00};
        vecs[1]  = '{0, 32'h08, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 32'hFFFFFFFF, 2'b00};
        vecs[2]  = '{0, 32'h08, 32'h11223344, 4'h5, 0, 3, 0, 32'hFF22FF44, 2'b00};
        vecs[3]  = '{1, 32'h08, 32'h0,        4'h0, 0, 0, 0, 32'hFF22FF44, 2'b00};
        vecs[4]  = '{0, 32'h00, 32'hCAFEF00D, 4'h3, 2, 0, 5, 32'h0000F00D, 2'b00};
        vecs[5]  = '{1, 32'h00, 32'h0,        4'h0, 1, 3, 0, 32'h0000F00D, 2'b00};
        vecs[6]  = '{1, 32'h20, 32'h0,        4'h0, 0, 0, 0, 32'h00000000, 2'b10};
        vecs[7]  = '{0, 32'h06, 32'h99887766, 4'hF, 0, 0, 1, 32'h0,        2'b10};
        vecs[8]  = '{1, 32'h04, 32'h0,        4'h0, 0, 2, 0, 32'hDEADBEEF, 2'b00};
        vecs[9]  = '{0, 32'h1C, 32'h12345678, 4'hC, 1, 1, 2, 32'h12340000, 2'b00};
        vecs[10] = '{1, 32'h1C, 32'h0,        4'h0, 0, 0, 0, 32'h12340000, 2'b00};
        vecs[11] = '{1, 32'h03, 32'h0,        4'h0, 0, 0, 0, 32'h00000000, 2'b10};
        vecs[12] = '{0, 32'h40, 32'h00000055, 4'hF, 0, 0, 0, 32'h0,        2'b10};
        vecs[13] = '{1, 32'hFFFFFFFC, 32'h0,  4'h0, 0, 0, 0, 32'h00000000, 2'b10};

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready_valid", {awready, wready, arready, bvalid, rvalid}, 5'b0);
        check("rst_resp_data", {bresp, rresp, rdata}, 36'h0);
        check("rst_pulse", reg_w_v, 8'h00);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", {awready, wready, arready}, 3'b111);
        check("post_rst_valid", {bvalid, rvalid}, 2'b00);
        check("post_rst_regs", regs, 256'h0);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].is_rd) begin
                do_read(vecs[i].addr, vecs[i].d1, vecs[i].d2, vecs[i].exp_data, vecs[i].exp_resp);
            end else begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].d1, vecs[i].d2, vecs[i].d3,
                         vecs[i].exp_resp);
                if (vecs[i].exp_resp == 2'b00)
                    check("tbl_reg_value", regs[vecs[i].addr[4:2]*32 +: 32], vecs[i].exp_data);
            end
        end

        for (int t = 0; t < 120; t++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = 32'($urandom_range(0, 7) * 4);
            else if (r == 7) a = 32'($urandom_range(0, 31));
            else             a = 32'($urandom_range(32, 200));
            d = $urandom;
            awprot = 3'($urandom_range(0, 7));
            arprot = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                do_read(a, $urandom_range(0, 3), $urandom_range(0, 3),
                        m_legal(a) ? model[a[4:2]] : 32'h0, m_legal(a) ? 2'b00 : 2'b10);
            end else begin
                do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), m_legal(a) ? 2'b00 : 2'b10);
            end
        end

        // Reset between AW and W: the captured AW must be forgotten.
        awaddr = 32'h04; awvalid = 1'b1;
        check("rstmid_aw_ready", awready, 1'b1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        check("rstmid_have_aw", {awready, wready}, 2'b01);
        reset = 1'b1;
        #1;
        check("rstmid_in_reset", {awready, wready, arready, bvalid}, 4'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < N; i++) model[i] = '0;
        #1;
        check("rstmid_idle", {awready, wready}, 2'b11);
        wdata = 32'h13579BDF; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        check("rstmid_no_bvalid", bvalid, 1'b0);
        check("rstmid_have_w", {awready, wready}, 2'b10);
        check("rstmid_regs", regs, 256'h0);
        check("rstmid_pulse", reg_w_v, 8'h00);
        awaddr = 32'h0C; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        model[3] = 32'h13579BDF;
        check("rstmid_fresh_bvalid", bvalid, 1'b1);
        check("rstmid_fresh_regs", regs, m_flat());
        check("rstmid_fresh_pulse", reg_w_v, 8'h08);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("rstmid_done", bvalid, 1'b0);
        $display("RSTMID fresh write addr=0c data=13579bdf");

        // Read accepted on the same edge as a write commit to the same register.
        old = model[1];
        awaddr = 32'h04; wdata = 32'hA5A5A5A5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h04; arvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        model[1] = 32'hA5A5A5A5;
        check("coll_rvalid", rvalid, 1'b1);
        check("coll_rdata_old", rdata, old);
        check("coll_bvalid", bvalid, 1'b1);
        check("coll_regs", regs, m_flat());
        rready = 1'b1; bready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0; bready = 1'b0;
        check("coll_done", {rvalid, bvalid}, 2'b00);
        $display("COLL addr=04 rdata=%h", old);
        do_read(32'h04, 0, 0, model[1], 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
